// File: rtl/meter_countdown.sv
// meter_countdown: parking-meter BCD countdown with add/load buttons and display blanking.
// Define METER_LOW_BLINK_EN to blink the display at 1 Hz while in the LOW state.
`timescale 1ns/1ps
module meter_countdown (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        blink_clk,
  input  logic        add_60,
  input  logic        add_120,
  input  logic        add_180,
  input  logic        add_300,
  input  logic        set_15,
  input  logic        set_150,
  output logic [15:0] time_bcd,
  output logic        display_on,
  output logic        expired,
  output logic        low_time
);
  typedef enum logic [1:0] {EXPIRED, LOW, NORMAL} state_t;
  state_t st, st_nx;
  logic [7:0] din, q1, q2, ev;
  logic [15:0] amt, t_add, t_nx;
  logic [16:0] sum;
  logic low_disp, disp_nx;
  function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
    logic [4:0] s;
    logic c;
    logic [15:0] r;
    c = 1'b0;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[4*i+:4]} + {1'b0, b[4*i+:4]} + {4'b0000, c};
      c = s > 5'd9;
      r[4*i+:4] = c ? s[3:0] + 4'd6 : s[3:0];
    end
    return {c, r};
  endfunction
  function automatic logic [15:0] bcd_dec(input logic [15:0] a);
    logic b;
    logic [15:0] r;
    b = 1'b1;
    r = a;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        r[4*i+:4] = (a[4*i+:4] == 4'd0) ? 4'd9 : a[4*i+:4] - 4'd1;
        b = (a[4*i+:4] == 4'd0);
      end
    end
    return r;
  endfunction
  assign din = {set_150, set_15, add_300, add_180, add_120, add_60, blink_clk, tick_1hz};
  assign ev  = q1 & ~q2;
`ifdef METER_LOW_BLINK_EN
  assign low_disp = q1[0];
`else
  assign low_disp = 1'b1;
`endif
  always_comb begin
    amt     = ev[5] ? 16'h0300 : ev[4] ? 16'h0180 : ev[3] ? 16'h0120 : ev[2] ? 16'h0060 : 16'h0000;
    sum     = bcd_add(time_bcd, amt);
    t_add   = sum[16] ? 16'h9999 : sum[15:0];
    t_nx    = ev[7] ? 16'h0150 : ev[6] ? 16'h0015 :
              (ev[0] && t_add != 16'h0000) ? bcd_dec(t_add) : t_add;
    st_nx   = (t_nx == 16'h0000) ? EXPIRED : (t_nx < 16'h0180) ? LOW : NORMAL;
    disp_nx = (st_nx == NORMAL) ? 1'b1 : (st_nx == LOW) ? low_disp : q1[1];
  end
  // Sync flops reset high so a button held through reset release is not an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1         <= '1;
      q2         <= '1;
      time_bcd   <= 16'h0000;
      st         <= EXPIRED;
      display_on <= 1'b0;
    end else begin
      q1         <= din;
      q2         <= q1;
      time_bcd   <= t_nx;
      st         <= st_nx;
      display_on <= disp_nx;
    end
  end
  assign expired  = (st == EXPIRED);
  assign low_time = (st == LOW);
endmodule

// File: tb/tb_meter_countdown.sv
// tb_meter_countdown: table vectors, corner sequences and random transactions vs a seconds-level model.
`timescale 1ns/1ps
module tb_meter_countdown;
  logic clk = 0, rst = 1;
  logic tick_1hz = 0, blink_clk = 0, add_60 = 0, add_120 = 0, add_180 = 0, add_300 = 0, set_15 = 0, set_150 = 0;
  logic [15:0] time_bcd;
  logic display_on, expired, low_time;
  int n_cmp = 0, n_bad = 0;
  int secs = 0;
`ifdef METER_LOW_BLINK_EN
  localparam logic LOW_DISP = 1'b0;
`else
  localparam logic LOW_DISP = 1'b1;
`endif
  localparam logic [6:0] TK = 7'h01, A60 = 7'h02, A120 = 7'h04, A180 = 7'h08, A300 = 7'h10, S15 = 7'h20, S150 = 7'h40;

  meter_countdown dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .blink_clk(blink_clk),
    .add_60(add_60), .add_120(add_120), .add_180(add_180), .add_300(add_300),
    .set_15(set_15), .set_150(set_150),
    .time_bcd(time_bcd), .display_on(display_on), .expired(expired), .low_time(low_time)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout sim did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [6:0]  mask;
    logic [15:0] t;
    logic        ex;
    logic        lo;
  } vec_t;

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] m);
    {set_150, set_15, add_300, add_180, add_120, add_60, tick_1hz} = m;
  endtask

  task automatic xact(input logic [6:0] m);
    @(negedge clk);
    drive(m);
    repeat (2) @(negedge clk);
    drive(7'h00);
    repeat (2) @(negedge clk);
  endtask

  task automatic model(input logic [6:0] m);
    int amt;
    if (m[6]) secs = 150;
    else if (m[5]) secs = 15;
    else begin
      amt = m[4] ? 300 : m[3] ? 180 : m[2] ? 120 : m[1] ? 60 : 0;
      secs = (secs + amt > 9999) ? 9999 : secs + amt;
      if (m[0] && secs > 0) secs--;
    end
  endtask

  task automatic step(input string name, input logic [6:0] m);
    xact(m);
    model(m);
    chk({name, " time"}, time_bcd, to_bcd(secs));
    chk({name, " expired"}, {15'd0, expired}, {15'd0, secs == 0});
    chk({name, " low"}, {15'd0, low_time}, {15'd0, secs > 0 && secs < 180});
    chk({name, " disp"}, {15'd0, display_on}, {15'd0, secs >= 180 ? 1'b1 : secs > 0 ? LOW_DISP : 1'b0});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    drive(7'h00);
    blink_clk = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    secs = 0;
    repeat (2) @(negedge clk);
  endtask

  vec_t tbl[11];
  logic [6:0] rm;

  initial begin
    tbl[0]  = '{A60, 16'h0060, 0, 1};
    tbl[1]  = '{TK, 16'h0059, 0, 1};
    tbl[2]  = '{TK, 16'h0058, 0, 1};
    tbl[3]  = '{TK, 16'h0057, 0, 1};
    tbl[4]  = '{TK, 16'h0056, 0, 1};
    tbl[5]  = '{TK, 16'h0055, 0, 1};
    tbl[6]  = '{S15 | TK, 16'h0015, 0, 1};
    tbl[7]  = '{A120 | A60 | TK, 16'h0134, 0, 1};
    tbl[8]  = '{S150 | A300, 16'h0150, 0, 1};
    tbl[9]  = '{A300 | A180, 16'h0450, 0, 0};
    tbl[10] = '{TK, 16'h0449, 0, 0};

    do_reset();
    chk("reset time", time_bcd, 16'h0000);
    chk("reset expired", {15'd0, expired}, 16'd1);
    chk("reset low", {15'd0, low_time}, 16'd0);
    chk("reset disp", {15'd0, display_on}, 16'd0);

    foreach (tbl[i]) begin
      xact(tbl[i].mask);
      chk($sformatf("vec%0d time", i), time_bcd, tbl[i].t);
      chk($sformatf("vec%0d expired", i), {15'd0, expired}, {15'd0, tbl[i].ex});
      chk($sformatf("vec%0d low", i), {15'd0, low_time}, {15'd0, tbl[i].lo});
    end

    // set_15 then count to zero, one extra tick, then blink tracking in EXPIRED
    do_reset();
    step("load15", S15);
    for (int i = 0; i < 16; i++) step("cnt15", TK);
    @(negedge clk); blink_clk = 1;
    @(negedge clk); chk("blink lag1", {15'd0, display_on}, 16'd0);
    @(negedge clk); chk("blink lag2", {15'd0, display_on}, 16'd1);
    blink_clk = 0;
    @(negedge clk); chk("blink fall1", {15'd0, display_on}, 16'd1);
    @(negedge clk); chk("blink fall2", {15'd0, display_on}, 16'd0);

    // LOW-state display behaviour
    step("low setup", A60);
    @(negedge clk); tick_1hz = 1;
    @(negedge clk);
    @(negedge clk); chk("low disp tick hi", {15'd0, display_on}, 16'd1);
    tick_1hz = 0; secs--;
    repeat (2) @(negedge clk);
    chk("low disp tick lo", {15'd0, display_on}, {15'd0, LOW_DISP});
    chk("low disp time", time_bcd, to_bcd(secs));

    // saturation
    do_reset();
    for (int i = 0; i < 34; i++) step("sat", A300);
    chk("sat value", time_bcd, 16'h9999);
    step("sat add+tick", A300 | TK);
    chk("sat add+tick value", time_bcd, 16'h9998);

    // 0100 with add_120+add_60+tick, and 0100 -> 0099
    do_reset();
    step("to100", S150);
    for (int i = 0; i < 50; i++) step("to100", TK);
    chk("at 0100", time_bcd, 16'h0100);
    step("combo", A120 | A60 | TK);
    chk("combo 0219", time_bcd, 16'h0219);
    do_reset();
    step("to100b", S150);
    for (int i = 0; i < 50; i++) step("to100b", TK);
    step("borrow 0099", TK);
    chk("borrow 0099 value", time_bcd, 16'h0099);

    // 1020 -> 1000 -> 0999
    do_reset();
    for (int i = 0; i < 3; i++) step("to1020", A300);
    step("to1020", A120);
    for (int i = 0; i < 20; i++) step("to1000", TK);
    chk("at 1000", time_bcd, 16'h1000);
    step("borrow 0999", TK);
    chk("borrow 0999 value", time_bcd, 16'h0999);

    // set_150 with tick from 0042
    do_reset();
    step("to42", A60);
    for (int i = 0; i < 18; i++) step("to42", TK);
    chk("at 0042", time_bcd, 16'h0042);
    step("set150 tick", S150 | TK);
    chk("set150 tick value", time_bcd, 16'h0150);

    // button held through reset release produces no add
    @(negedge clk); rst = 1; add_300 = 1;
    repeat (2) @(negedge clk); rst = 0; secs = 0;
    repeat (3) @(negedge clk);
    chk("held thru rst", time_bcd, 16'h0000);
    add_300 = 0;
    repeat (2) @(negedge clk);
    step("after held", A60);

    // asynchronous reset mid-count at 0180
    do_reset();
    step("to180", A180);
    chk("at 0180 disp", {15'd0, display_on}, 16'd1);
    @(negedge clk); #2 rst = 1;
    #1;
    chk("async rst time", time_bcd, 16'h0000);
    chk("async rst expired", {15'd0, expired}, 16'd1);
    chk("async rst low", {15'd0, low_time}, 16'd0);
    chk("async rst disp", {15'd0, display_on}, 16'd0);
    @(negedge clk); rst = 0; secs = 0;
    repeat (2) @(negedge clk);

    // random transactions vs model
    for (int i = 0; i < 300; i++) begin
      rm = 7'h00;
      rm[0] = $urandom_range(0, 99) < 50;
      for (int b = 1; b < 5; b++) rm[b] = $urandom_range(0, 99) < 12;
      rm[5] = $urandom_range(0, 99) < 3;
      rm[6] = $urandom_range(0, 99) < 3;
      step("rand", rm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
